frame_decoder: RTL
==================

# frame_decoder

Frame decoder stage fed directly by the 40 MHz-sampled CDR: consumes the recovered 10 Mbps bit stream (one data bit per enable strobe), hunts for a sync word, deserializes a 16-bit payload and checks a CRC-8. It presents validated control words to the DRSSTC drive logic. It also maintains link-lock status, a loss-of-signal timeout and a saturating error counter.

## Interface
- SYNC_WORD, 8'hA7, frame sync pattern, MSB first
- LOCK_FRAMES, 4, consecutive good frames needed to assert link-up (1..15)
- TIMEOUT_CYC, 4000, i_clk cycles without a good frame before link drop (100 us @ 40 MHz); counter width $clog2(TIMEOUT_CYC+1)

Ports:
- i_clk  in  1  40 MHz clock, single clock domain
- i_res_n  in  1  reset, synchronous, active-low
- i_RecoveryData  in  1  recovered bit from CDR, valid only when i_DataEn=1
- i_DataEn  in  1  one-cycle bit strobe, nominally every 4th cycle
- o_Data  out  16  last CRC-good payload, MSB = first received
- o_DataValid  out  1  one-cycle pulse, o_Data just updated
- o_CrcErr  out  1  one-cycle pulse, frame failed CRC
- o_LinkUp  out  1  link locked
- o_ErrCnt  out  8  CRC-error count, saturates at 255

## Operation
- Frame, MSB first: SYNC_WORD (8b), payload (16b), CRC (8b); 32 bits total, no inter-frame gap required.
- CRC-8: polynomial x^8+x^2+x+1 (0x07), init 8'h00, no reflection, no final XOR; computed serially over the 16 payload bits only.
- All state changes happen only on cycles with i_DataEn=1, except the timeout and reset.
- States:
  - HUNT: 8-bit shift register takes each bit. If {sr[6:0], bit} == SYNC_WORD, go to PAYLOAD, clear the bit counter, and set CRC to 8'h00.
  - PAYLOAD: shift the bit into the payload register and the CRC engine. After the 16th bit, go to CHECK and clear the bit counter.
  - CHECK: shift the bit into the received-CRC register. After the 8th bit, compare it with the computed CRC and return to HUNT.
- Good frame: o_Data <= payload, pulse o_DataValid, good-frame counter +1 (saturating at LOCK_FRAMES), timeout counter cleared.
- Bad frame:
  - Pulse o_CrcErr; o_ErrCnt +1 (saturating at 255).
  - Good-frame counter cleared; o_LinkUp cleared; o_Data unchanged.
- o_LinkUp sets when the good-frame counter reaches LOCK_FRAMES. It clears on a bad frame or a timeout.
- Timeout counter:
  - Increments every i_clk and saturates at TIMEOUT_CYC.
  - On reaching TIMEOUT_CYC: o_LinkUp <= 0, good-frame counter <= 0, and state forced to HUNT (mid-frame partial data discarded).
  - Timeout expiry and a good-frame completion in the same cycle: good frame wins, counter cleared, link unaffected.
- The HUNT shift register is not cleared on frame end. After a frame, re-sync requires 8 fresh bits matching SYNC_WORD. Sync-like patterns inside the payload are ignored (not in HUNT).

## Timing
- Reset (i_res_n=0 at a rising edge): state HUNT, all registers 0.
  - o_Data=16'h0000, o_DataValid=0, o_CrcErr=0, o_LinkUp=0, o_ErrCnt=8'h00.
  - Reset mid-frame abandons the frame with no pulse.
- Latency: o_DataValid / o_CrcErr assert on the cycle after the i_DataEn cycle carrying the last CRC bit. o_Data is valid on that same cycle.
- o_LinkUp changes on the same cycle as the o_DataValid / o_CrcErr pulse that causes it.
- o_DataValid and o_CrcErr are mutually exclusive and never longer than 1 cycle.
- Bursty or irregular i_DataEn spacing (including back-to-back strobes) is tolerated; only the strobe count matters.

## Test plan
- Reset, then frame A7 / payload 16'h0001 / CRC 8'h07 -> one o_DataValid pulse 1 cycle after the last bit; o_Data=16'h0001, o_CrcErr=0, o_LinkUp=0.
- 4 back-to-back frames with payload 16'h0100 and CRC 8'h15 -> 4 o_DataValid pulses; o_LinkUp rises with the 4th pulse; o_ErrCnt=0.
- From locked state, send payload 16'h0100 with CRC 8'h14 -> o_CrcErr pulse, o_LinkUp=0, o_ErrCnt=1, o_Data stays 16'h0100.
- From locked state, stop i_DataEn for 4000 cycles -> o_LinkUp falls exactly at count 4000. Sending 16 random bits then a valid frame -> decoded correctly.
- 300 bad-CRC frames -> o_ErrCnt saturates at 8'hFF with no wrap. Payload 16'h00A7 (embedded sync) is decoded normally.
- Assert i_res_n=0 for 1 cycle after 20 bits of a frame -> all outputs at reset values, no pulse. The next full valid frame decodes.

Source files
------------

// File: rtl/frame_decoder.sv
// frame_decoder
//
// Serial frame decoder behind the CDR. One recovered bit arrives per i_DataEn strobe.
// The block hunts for SYNC_WORD, deserializes a 16-bit payload, checks it against the
// CRC-8 that follows (poly 0x07, init 0, MSB first) and publishes good payloads. It also
// tracks link lock (LOCK_FRAMES consecutive good frames), a loss-of-signal timeout
// (TIMEOUT_CYC clocks without a good frame) and a saturating CRC error counter.
//
// Ports:
//   i_clk           clock, single domain
//   i_res_n         synchronous active-low reset
//   i_RecoveryData  recovered bit, valid while i_DataEn=1
//   i_DataEn        one-cycle bit strobe
//   o_Data          last CRC-good payload, MSB = first received bit
//   o_DataValid     one-cycle pulse, o_Data just updated
//   o_CrcErr        one-cycle pulse, frame failed CRC
//   o_LinkUp        link locked
//   o_ErrCnt        CRC error count, saturates at 255
module frame_decoder #(
  parameter logic [7:0]  SYNC_WORD   = 8'hA7,
  parameter int unsigned LOCK_FRAMES = 4,
  parameter int unsigned TIMEOUT_CYC = 4000
) (
  input  logic        i_clk,
  input  logic        i_res_n,
  input  logic        i_RecoveryData,
  input  logic        i_DataEn,
  output logic [15:0] o_Data,
  output logic        o_DataValid,
  output logic        o_CrcErr,
  output logic        o_LinkUp,
  output logic [7:0]  o_ErrCnt
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned GW = $clog2(LOCK_FRAMES + 1);
  localparam logic [TW-1:0] ToMax   = TW'(TIMEOUT_CYC);
  localparam logic [GW-1:0] LockMax = GW'(LOCK_FRAMES);
  localparam logic [7:0]    CrcPoly = 8'h07;

  typedef enum logic [1:0] {StHunt, StPayload, StCheck} state_e;

  state_e        state_q, state_d;
  // In StHunt counts fresh bits (saturating at 7); otherwise counts bits of the field.
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    sr_q, sr_d;
  logic [15:0]   payload_q, payload_d;
  logic [7:0]    crc_q, crc_d;
  logic [7:0]    rx_crc_q, rx_crc_d;
  logic [15:0]   data_q, data_d;
  logic          dv_q, dv_d;
  logic          ce_q, ce_d;
  logic          link_q, link_d;
  logic [7:0]    err_q, err_d;
  logic [GW-1:0] good_q, good_d;
  logic [TW-1:0] to_q, to_d;

  logic [7:0] sr_shift;
  logic [7:0] rx_full;
  logic [7:0] crc_next;
  logic       crc_fb;
  logic       frame_done;
  logic       crc_ok;
  logic       to_hit;

  always_comb begin
    sr_shift   = {sr_q[6:0], i_RecoveryData};
    rx_full    = {rx_crc_q[6:0], i_RecoveryData};
    crc_fb     = crc_q[7] ^ i_RecoveryData;
    crc_next   = {crc_q[6:0], 1'b0} ^ (crc_fb ? CrcPoly : 8'h00);
    frame_done = i_DataEn && (state_q == StCheck) && (cnt_q == 4'd7);
    crc_ok     = (rx_full == crc_q);
    // Fires once, on the clock where the idle counter reaches its limit.
    to_hit     = (to_q == ToMax - 1'b1);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    payload_d = payload_q;
    crc_d     = crc_q;
    rx_crc_d  = rx_crc_q;
    data_d    = data_q;
    dv_d      = 1'b0;
    ce_d      = 1'b0;
    link_d    = link_q;
    err_d     = err_q;
    good_d    = good_q;
    to_d      = (to_q == ToMax) ? to_q : to_q + 1'b1;

    if (to_hit && !frame_done) begin
      // Loss of signal: drop lock and abandon any partial frame; the bit is discarded.
      state_d = StHunt;
      cnt_d   = 4'd0;
      link_d  = 1'b0;
      good_d  = '0;
    end else if (i_DataEn) begin
      case (state_q)
        StHunt: begin
          sr_d = sr_shift;
          if ((cnt_q == 4'd7) && (sr_shift == SYNC_WORD)) begin
            state_d = StPayload;
            cnt_d   = 4'd0;
            crc_d   = 8'h00;
          end else if (cnt_q != 4'd7) begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        StPayload: begin
          payload_d = {payload_q[14:0], i_RecoveryData};
          crc_d     = crc_next;
          if (cnt_q == 4'd15) begin
            state_d = StCheck;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        StCheck: begin
          rx_crc_d = rx_full;
          if (cnt_q == 4'd7) begin
            state_d = StHunt;
            cnt_d   = 4'd0;
            if (crc_ok) begin
              data_d = payload_q;
              dv_d   = 1'b1;
              to_d   = '0;
              good_d = (good_q == LockMax) ? good_q : good_q + 1'b1;
              link_d = (good_d == LockMax);
            end else begin
              ce_d   = 1'b1;
              err_d  = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
              good_d = '0;
              link_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: begin
          state_d = StHunt;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_res_n) begin
      state_q   <= StHunt;
      cnt_q     <= 4'd0;
      sr_q      <= 8'h00;
      payload_q <= 16'h0000;
      crc_q     <= 8'h00;
      rx_crc_q  <= 8'h00;
      data_q    <= 16'h0000;
      dv_q      <= 1'b0;
      ce_q      <= 1'b0;
      link_q    <= 1'b0;
      err_q     <= 8'h00;
      good_q    <= '0;
      to_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      payload_q <= payload_d;
      crc_q     <= crc_d;
      rx_crc_q  <= rx_crc_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      ce_q      <= ce_d;
      link_q    <= link_d;
      err_q     <= err_d;
      good_q    <= good_d;
      to_q      <= to_d;
    end
  end

  assign o_Data      = data_q;
  assign o_DataValid = dv_q;
  assign o_CrcErr    = ce_q;
  assign o_LinkUp    = link_q;
  assign o_ErrCnt    = err_q;

endmodule
